fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Fetch stage control, sits between the PC register and decode in the three-stage RV32IS pipeline.
- Owns the fetch PC. Issues instruction-memory requests with a valid/ready handshake and captures responses into the IF/DE pipeline register.
- Absorbs decode back-pressure with a 1-entry skid buffer.
- Applies branch/jump redirects from execute and discards in-flight stale responses.

Parameters:
- INIT_PC, 32'h0000_0200, fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction word driven on de_inst when de_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, posedge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  execute-stage taken branch/jump
- redirect_pc  in  32  redirect target
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  32  fetch address (= pc)
- imem_resp_valid  in  1  instruction returned, exactly one per accepted request, ≥1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- de_valid  out  1  IF/DE register holds an instruction
- de_ready  in  1  decode consumes this cycle
- de_inst  out  32  instruction to decode
- de_pc  out  32  address of de_inst
- pc  out  32  current fetch PC

Behaviour:
- Reset (async, rst_n=0):
  - pc=INIT_PC, state=IDLE, imem_req_valid=0.
  - de_valid=0, de_inst=NOP_INST, de_pc=0, skid empty.
- FSM states: IDLE, REQ, WAIT, DROP. At most one outstanding request.
- IDLE:
  - Go to REQ when the skid buffer is empty.
  - Redirect: pc<=redirect_pc.
- REQ:
  - imem_req_valid = !redirect_valid; imem_req_addr=pc.
  - Valid/addr stay stable until accepted. The only exception is redirect, which retracts the request for that cycle.
  - Accept (valid&ready): pc<=pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - Redirect: pc<=redirect_pc, stay in REQ.
- WAIT, on imem_resp_valid (no redirect):
  - Write {imem_resp_data, pc-4} into the IF/DE register if de_valid=0 or de_ready=1. Otherwise write it into the skid buffer.
  - Next state: REQ if the skid buffer will be empty, else IDLE.
- WAIT, with redirect:
  - pc<=redirect_pc.
  - If imem_resp_valid in the same cycle: discard the response, go to REQ. Otherwise go to DROP.
- DROP:
  - imem_resp_valid discards the response and goes to REQ.
  - Redirect in DROP updates pc and stays in DROP.
- IF/DE handshake:
  - Transfer occurs on de_valid&de_ready.
  - Skid buffer drains into IF/DE before any new response. Order is preserved.
  - de_valid=0 forces de_inst=NOP_INST.
- Redirect flush: same cycle, next edge de_valid<=0 and skid emptied, regardless of de_ready.
- Latency:
  - Redirect at cycle N gives imem_req_addr=redirect_pc at N+1.
  - With a 1-cycle imem, the response arrives at N+2 and de_valid=1 at N+3.
- Throughput: 1 instruction per 2 cycles with a 1-cycle imem (REQ→WAIT→REQ).
- Skid full with de_ready=0: no new request is issued, and pc holds.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - Adds output port fetch_fault (1 bit).
  - A redirect with redirect_pc[1:0]!=0 issues no request.
  - The block loads IF/DE with de_valid=1, de_inst=NOP_INST, de_pc=redirect_pc, fetch_fault=1, then parks in IDLE until the next redirect.
  - fetch_fault clears when that entry transfers.
- Not defined: the port is absent and redirect_pc[1:0] is forced to 2'b00.

Decomposition:
- riscv.vh: INIT_PC and NOP encoding constants, 32-bit width macro, 2-bit fetch-state encodings.
- One sub-module, if_de_reg: IF/DE register plus 1-entry skid buffer with valid/ready and a flush input.

Test Plan:
- Reset release, imem ready=1, 1-cycle response, de_ready=1 → requests at 0x200, 0x204, 0x208; de_pc sequence 0x200, 0x204 with matching de_inst, one every 2 cycles.
- de_ready=0 for 6 cycles after the first instruction → IF/DE holds 0x200, skid holds 0x204, no request for 0x208 until de_ready=1; order is preserved.
- Redirect to 0x400 while in WAIT (response for 0x208 arrives 1 cycle later) → the 0x208 word is dropped, next request is 0x400, next de_pc=0x400; de_valid=0 the cycle after the redirect.
- Redirect coincident with imem_resp_valid and imem_req_ready held 0 → response discarded, imem_req_valid deasserted that cycle, then 0x400 is requested.
- Start from 0xFFFF_FFFC → next request address 0x0000_0000.
- rst_n low mid-WAIT → all outputs return to reset values immediately (async), fetch restarts at 0x200. With FETCH_MISALIGN_EN, redirect to 0x402 → fetch_fault=1 with de_pc=0x402 and no imem request.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and the IF/DE entry type for the fetch stage.
package fetch_unit_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] INIT_PC_DEF  = 32'h0000_0200;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;   // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if_de.sv
// IF/DE pipeline register with a 1-entry skid buffer. Flush empties both
// stages; an entry offered together with flush lands in the cleared register.
module if_de_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_entry,
  output logic         skid_valid
);

  fetch_entry_t main_q, skid_q;
  logic         main_valid;
  logic         drain;

  // Register can take a new entry when empty or being consumed this cycle.
  assign drain = !main_valid || out_ready;

  // Skid drains ahead of any new entry so program order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_q     <= '{inst: NOP_INST, pc: '0, fault: 1'b0};
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= in_valid;
      skid_valid <= 1'b0;
      if (in_valid) main_q <= in_entry;
    end else if (drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_q     <= skid_q;
        skid_valid <= in_valid;
        if (in_valid) skid_q <= in_entry;
      end else begin
        main_valid <= in_valid;
        if (in_valid) main_q <= in_entry;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_q     <= in_entry;
    end
  end

  assign out_valid = main_valid;
  assign out_entry = '{inst:  main_valid ? main_q.inst : NOP_INST,
                       pc:    main_q.pc,
                       fault: main_valid & main_q.fault};

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one imem request at a time, feeds
// IF/DE through a skid buffer and drops responses made stale by redirects.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect -> fetch_fault).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] INIT_PC  = INIT_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        de_valid,
  input  logic        de_ready,
  output logic [31:0] de_inst,
  output logic [31:0] de_pc,
  output logic [31:0] pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_fault
`endif
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_n, rpc;
  logic         parked, parked_n;
  logic         misalign;
  logic         wr_valid, skid_valid;
  fetch_entry_t wr_entry, de_entry;

`ifdef FETCH_MISALIGN_EN
  assign rpc      = redirect_pc;
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_rpc_lo;
  assign rpc           = {redirect_pc[31:2], 2'b00};
  assign misalign      = 1'b0;
  assign unused_rpc_lo = ^redirect_pc[1:0];
`endif

  // State, PC and fault-park registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc     <= INIT_PC;
      parked <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      parked <= parked_n;
    end
  end

  // Next-state, PC update and IF/DE write; redirect overrides the normal flow.
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    parked_n       = parked;
    wr_valid       = 1'b0;
    wr_entry       = '{inst: imem_resp_data, pc: pc - 32'd4, fault: 1'b0};
    imem_req_valid = (state == ST_REQ) && !redirect_valid;
    unique case (state)
      ST_IDLE: if (!skid_valid && !parked) state_n = ST_REQ;
      ST_REQ: begin
        if (imem_req_valid && imem_req_ready) begin
          pc_n    = pc + 32'd4;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          wr_valid = 1'b1;
          // Skid stays empty only when the response goes straight to IF/DE.
          state_n  = (!skid_valid && (!de_valid || de_ready)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: if (imem_resp_valid) state_n = parked ? ST_IDLE : ST_REQ;
      default: state_n = ST_IDLE;
    endcase
    if (redirect_valid) begin
      pc_n     = rpc;
      parked_n = 1'b0;
      wr_valid = 1'b0;
      if (state == ST_WAIT || state == ST_DROP)
        state_n = imem_resp_valid ? ST_REQ : ST_DROP;
      if (misalign) begin
        // Fault entry goes straight to decode; wait out any in-flight response.
        wr_valid = 1'b1;
        wr_entry = '{inst: NOP_INST, pc: rpc, fault: 1'b1};
        parked_n = 1'b1;
        state_n  = ((state == ST_WAIT || state == ST_DROP) && !imem_resp_valid)
                   ? ST_DROP : ST_IDLE;
      end
    end
  end

  if_de_reg #(.NOP_INST(NOP_INST)) u_if_de (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .in_valid   (wr_valid),
    .in_entry   (wr_entry),
    .out_valid  (de_valid),
    .out_ready  (de_ready),
    .out_entry  (de_entry),
    .skid_valid (skid_valid)
  );

  assign imem_req_addr = pc;
  assign de_inst       = de_entry.inst;
  assign de_pc         = de_entry.pc;

`ifdef FETCH_MISALIGN_EN
  assign fetch_fault = de_entry.fault;
`else
  logic unused_fault;
  assign unused_fault = de_entry.fault;
`endif

endmodule
